// File: rtl/xyscan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : xyscan_counter
//  Description : Raster (x,y) position counter with free-run and single-frame
//                modes. The optional frame counter output is enabled by the
//                macro XYSCAN_FRAME_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module xyscan_counter #(
    parameter int XW  = 10,
    parameter int YW  = 10,
    parameter int FCW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          start,
    input  logic          stop,
    input  logic          single,
    input  logic [XW-1:0] x_limit,
    input  logic [YW-1:0] y_limit,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          busy,
    output logic          eol,
    output logic          eof,
    output logic          done
`ifdef XYSCAN_FRAME_CNT_EN
   ,output logic [FCW-1:0] frame_count
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] xlim_q, xlim_d;
    logic [YW-1:0] ylim_q, ylim_d;
    logic          single_q, single_d;
    logic          done_q, done_d;
    logic          w_run;
    logic          w_eol;
    logic          w_eof;

    // Line/frame ends decode only registered state so they stay stable while enable is low.
    assign w_run = (state_q == ST_RUN);
    assign w_eol = w_run && (x_q == xlim_q);
    assign w_eof = w_eol && (y_q == ylim_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            xlim_q   <= '0;
            ylim_q   <= '0;
            single_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xlim_q   <= xlim_d;
            ylim_q   <= ylim_d;
            single_q <= single_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        xlim_d   = xlim_q;
        ylim_d   = ylim_q;
        single_d = single_q;
        done_d   = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        xlim_d   = x_limit;
                        ylim_d   = y_limit;
                        single_d = single;
                        x_d      = '0;
                        y_d      = '0;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (w_eof) begin
                            x_d = '0;
                            y_d = '0;
                            if (single_q) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else if (w_eol) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end
            endcase
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign busy = w_run;
    assign eol  = w_eol;
    assign eof  = w_eof;
    assign done = done_q;

`ifdef XYSCAN_FRAME_CNT_EN
    logic [FCW-1:0] fcnt_q, fcnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    // A stop in the same cycle as the last position leaves the count unchanged.
    always_comb begin
        fcnt_d = fcnt_q;
        if (!stop) begin
            if ((state_q == ST_IDLE) && start) begin
                fcnt_d = '0;
            end else if (w_run && enable && w_eof) begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

    assign frame_count = fcnt_q;
`else
    // FCW only sizes frame_count, which is absent in this build.
    if (FCW > 0) begin : g_no_frame_cnt
    end
`endif

endmodule
`default_nettype wire
